pc_ctrl: RTL and testbench
==========================

# pc_ctrl

Program-counter and fetch-redirect controller for the CPU. It sits directly downstream of the execute-stage branch comparator. It consumes the resolved `bcomp` flag together with the decoded control-transfer type. From these it computes the next fetch address, drives the instruction-fetch request handshake, and issues the flush that squashes wrong-path instructions. Branches are statically predicted not-taken; every taken transfer is a redirect.

## Interface
- `RESET_PC`, default 32'h0000_0000: fetch address after reset. Must be 4-byte aligned.
- `FLUSH_CYCLES`, default 2: number of cycles `flush_o` is held per redirect. Legal range is 1..15.

Ports:
- `clk`, in, 1: sole clock. All state updates on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `stall`, in, 1: pipeline hold. Blocks PC increment only.
- `if_ready`, in, 1: instruction memory accepts the request this cycle.
- `ex_valid`, in, 1: the execute-stage instruction is real (not a bubble).
- `ex_is_branch`, in, 1: conditional branch in execute.
- `ex_is_jal`, in, 1: JAL in execute.
- `ex_is_jalr`, in, 1: JALR in execute.
- `bcomp`, in, 1: branch comparator result.
- `ex_pc`, in, 32: PC of the execute-stage instruction.
- `ex_imm`, in, 32 signed: sign-extended immediate.
- `ex_rs1`, in, 32: rs1 operand, used for JALR.
- `pc_o`, out, 32: current fetch address.
- `if_valid`, out, 1: fetch request valid.
- `flush_o`, out, 1: squash IF/ID contents.
- `redirect_o`, out, 1: one-cycle pulse marking the first cycle at a new target.
- `misalign_o`, out, 1: sticky flag for a misaligned control-transfer target.

## Operation
- FSM states are IDLE, RUN, FLUSH and TRAP. All outputs are registered.
- Taken condition: `ex_valid & (ex_is_jalr | ex_is_jal | (ex_is_branch & bcomp))`.
  - Flag priority is jalr > jal > branch.
  - A not-taken branch causes no action.
- Target computation, modulo 2^32 with no overflow detection:
  - JALR: `(ex_rs1 + ex_imm) & ~32'h1`.
  - Otherwise: `ex_pc + ex_imm`.
- IDLE, entered on reset:
  - `pc_o=RESET_PC`, `if_valid=0`, `flush_o=0`, `redirect_o=0`, `misalign_o=0`, flush counter = 0.
  - Unconditionally moves to RUN on the next edge.
- RUN:
  - `if_valid=1`.
  - If taken and `target[1:0]==0`: `pc_o<=target`, `redirect_o<=1`, `flush_o<=1`, counter <= FLUSH_CYCLES-1, state moves to FLUSH (or directly to RUN with flush done if FLUSH_CYCLES==1).
  - If taken and target is misaligned: `pc_o<=target`, `misalign_o<=1`, state moves to TRAP.
  - Otherwise, if `if_ready & ~stall`: `pc_o<=pc_o+4`. 0xFFFF_FFFC wraps to 0.
  - Otherwise `pc_o` holds.
- FLUSH:
  - `if_valid=0`, `flush_o=1`, `pc_o` holds the target.
  - `ex_valid` and all execute inputs are ignored, because they belong to the wrong path.
  - `stall` does not freeze the counter. The counter decrements every cycle.
  - On reaching 0, state moves to RUN and `flush_o<=0`.
- TRAP:
  - `if_valid=0`, `flush_o=1`, `misalign_o=1`, `pc_o` holds the faulting target.
  - All inputs are ignored. Only `rst` exits this state.
- `rst` has priority over everything in every state, including mid-FLUSH and TRAP. The cycle after `rst` is sampled high, the block shows IDLE values.

## Timing
- Taken transfer resolved in cycle N (sampled at the edge ending N):
  - Cycles N+1 through N+FLUSH_CYCLES: `pc_o=target`, `flush_o=1`, `if_valid=0`.
  - Cycle N+1 only: `redirect_o=1`.
  - Cycle N+FLUSH_CYCLES+1: `if_valid=1` at the target.
- Redirect and fetch handshake in the same cycle: the redirect wins and the +4 increment is discarded.
- Redirect with `stall=1`: the redirect is still taken. `stall` gates only the increment.
- Fetch request stability: once `if_valid=1`, `pc_o` does not change until `if_ready` is seen or a redirect or reset occurs.
- Reset-to-first-fetch latency is 1 cycle: IDLE, then RUN.

## Test plan
- Reset release with `if_ready=1` and no transfers:
  - Required: `pc_o` = 0 (IDLE), 0, 4, 8, … and `if_valid` rises in the second post-reset cycle.
- BEQ in RUN with `ex_pc=0x100`, `ex_imm=-16`, `bcomp=1`:
  - Required next cycle: `pc_o=0xF0`, `redirect_o=1`.
  - Required: `flush_o=1` for exactly 2 cycles, then `if_valid=1` at 0xF0.
  - With `bcomp=0`, there is no flush and the PC keeps incrementing.
- JALR with `ex_rs1=0x2001`, `ex_imm=3`:
  - Required: target 0x2004 and a normal redirect.
  - With `ex_imm=1`, the target is 0x2002: `misalign_o=1`, TRAP; the block stays there until `rst`, then returns to IDLE values.
- Simultaneous events, with `stall=1`, `if_ready=1` and JAL `ex_pc=0x40`, `ex_imm=0x20` all asserted:
  - Required: `pc_o=0x60` next cycle.
  - Separately, `stall=1` alone holds `pc_o` unchanged for 5 cycles.
- Wrap-around with `pc_o=0xFFFF_FFFC` and a handshake:
  - Required: `pc_o=0`.
  - During FLUSH, drive `ex_valid=1` with a taken branch: required that it is ignored and the target is unchanged.
- `rst` asserted in the second FLUSH cycle:
  - Required next cycle: `pc_o=RESET_PC`, `flush_o=0`, `if_valid=0`, `redirect_o=0`.

Source files
------------

// File: rtl/pc_ctrl.sv
// Program-counter and fetch-redirect controller: tracks the fetch address, raises
// the fetch request, and flushes the front end when execute resolves a taken transfer.
module pc_ctrl #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          FLUSH_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               if_ready,
    input  logic               ex_valid,
    input  logic               ex_is_branch,
    input  logic               ex_is_jal,
    input  logic               ex_is_jalr,
    input  logic               bcomp,
    input  logic [31:0]        ex_pc,
    input  logic signed [31:0] ex_imm,
    input  logic [31:0]        ex_rs1,
    output logic [31:0]        pc_o,
    output logic               if_valid,
    output logic               flush_o,
    output logic               redirect_o,
    output logic               misalign_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        TRAP  = 2'd3
    } state_t;

    // Counter holds the flush cycles still to go after the current one.
    localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES - 1);

    state_t      r_state;
    logic [31:0] r_pc;
    logic        r_ifValid;
    logic        r_flush;
    logic        r_redirect;
    logic        r_misalign;
    logic [3:0]  r_flushCnt;

    state_t      w_nextState;
    logic [31:0] w_nextPc;
    logic        w_nextIfValid;
    logic        w_nextFlush;
    logic        w_nextRedirect;
    logic        w_nextMisalign;
    logic [3:0]  w_nextCnt;

    logic [31:0] w_jalrTarget;
    logic [31:0] w_relTarget;
    logic [31:0] w_target;
    logic        w_taken;
    logic        w_misaligned;

    // JALR wins over JAL/branch when several type flags are set at once.
    assign w_jalrTarget = (ex_rs1 + ex_imm) & ~32'h1;
    assign w_relTarget  = ex_pc + ex_imm;
    assign w_target     = ex_is_jalr ? w_jalrTarget : w_relTarget;
    assign w_taken      = ex_valid & (ex_is_jalr | ex_is_jal | (ex_is_branch & bcomp));
    assign w_misaligned = (w_target[1:0] != 2'b00);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_pc       <= RESET_PC;
            r_ifValid  <= 1'b0;
            r_flush    <= 1'b0;
            r_redirect <= 1'b0;
            r_misalign <= 1'b0;
            r_flushCnt <= 4'd0;
        end else begin
            r_state    <= w_nextState;
            r_pc       <= w_nextPc;
            r_ifValid  <= w_nextIfValid;
            r_flush    <= w_nextFlush;
            r_redirect <= w_nextRedirect;
            r_misalign <= w_nextMisalign;
            r_flushCnt <= w_nextCnt;
        end
    end

    always_comb begin
        w_nextState    = r_state;
        w_nextPc       = r_pc;
        w_nextIfValid  = r_ifValid;
        w_nextFlush    = r_flush;
        w_nextRedirect = 1'b0;
        w_nextMisalign = r_misalign;
        w_nextCnt      = r_flushCnt;

        case (r_state)
            IDLE: begin
                w_nextState   = RUN;
                w_nextIfValid = 1'b1;
                w_nextFlush   = 1'b0;
            end
            RUN: begin
                if (w_taken && !w_misaligned) begin
                    w_nextState    = FLUSH;
                    w_nextPc       = w_target;
                    w_nextRedirect = 1'b1;
                    w_nextFlush    = 1'b1;
                    w_nextIfValid  = 1'b0;
                    w_nextCnt      = FLUSH_INIT;
                end else if (w_taken) begin
                    w_nextState    = TRAP;
                    w_nextPc       = w_target;
                    w_nextMisalign = 1'b1;
                    w_nextFlush    = 1'b1;
                    w_nextIfValid  = 1'b0;
                end else if (if_ready && !stall) begin
                    w_nextPc = r_pc + 32'd4;
                end
            end
            // Execute inputs here belong to the squashed path, so only the counter matters.
            FLUSH: begin
                if (r_flushCnt == 4'd0) begin
                    w_nextState   = RUN;
                    w_nextFlush   = 1'b0;
                    w_nextIfValid = 1'b1;
                end else begin
                    w_nextCnt = r_flushCnt - 4'd1;
                end
            end
            TRAP: begin
                w_nextState = TRAP;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    assign pc_o       = r_pc;
    assign if_valid   = r_ifValid;
    assign flush_o    = r_flush;
    assign redirect_o = r_redirect;
    assign misalign_o = r_misalign;

endmodule

// File: tb/tb_pc_ctrl.sv
// Directed bench for pc_ctrl: a cycle-by-cycle vector table followed by
// hand-written sequences for reset mid-flush and a multi-cycle stall.
module tb_pc_ctrl;

    typedef struct packed {
        logic        rst;
        logic        stall;
        logic        rdy;
        logic [3:0]  ctl;       // {ex_valid, branch, jal, jalr}
        logic        bc;
        logic [31:0] exPc;
        logic [31:0] exImm;
        logic [31:0] exRs1;
        logic [31:0] expPc;
        logic [3:0]  expFlags;  // {if_valid, flush_o, redirect_o, misalign_o}
    } vec_t;

    localparam logic [3:0] C_NONE = 4'b0000;
    localparam logic [3:0] C_BR   = 4'b1100;
    localparam logic [3:0] C_JAL  = 4'b1010;
    localparam logic [3:0] C_JALR = 4'b1001;
    localparam logic [3:0] C_BOTH = 4'b1011;
    localparam logic [3:0] C_XJAL = 4'b0010;

    localparam logic [3:0] F_IDLE  = 4'b0000;
    localparam logic [3:0] F_RUN   = 4'b1000;
    localparam logic [3:0] F_REDIR = 4'b0110;
    localparam logic [3:0] F_FLUSH = 4'b0100;
    localparam logic [3:0] F_TRAP  = 4'b0101;

    localparam int NVEC = 32;

    logic               clk;
    logic               rst;
    logic               stall;
    logic               if_ready;
    logic               ex_valid;
    logic               ex_is_branch;
    logic               ex_is_jal;
    logic               ex_is_jalr;
    logic               bcomp;
    logic [31:0]        ex_pc;
    logic signed [31:0] ex_imm;
    logic [31:0]        ex_rs1;
    logic [31:0]        pc_o;
    logic               if_valid;
    logic               flush_o;
    logic               redirect_o;
    logic               misalign_o;

    int testCount = 0;
    int failCount = 0;
    vec_t vecs [NVEC];

    pc_ctrl #(.RESET_PC(32'h0000_0000), .FLUSH_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .stall(stall), .if_ready(if_ready),
        .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_is_jal(ex_is_jal),
        .ex_is_jalr(ex_is_jalr), .bcomp(bcomp), .ex_pc(ex_pc), .ex_imm(ex_imm),
        .ex_rs1(ex_rs1), .pc_o(pc_o), .if_valid(if_valid), .flush_o(flush_o),
        .redirect_o(redirect_o), .misalign_o(misalign_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic s, input logic rd,
                                input logic [3:0] c, input logic b,
                                input logic [31:0] pc, input logic [31:0] imm,
                                input logic [31:0] rs1, input logic [31:0] ePc,
                                input logic [3:0] eFl);
        vec_t v;
        v.rst = r; v.stall = s; v.rdy = rd; v.ctl = c; v.bc = b;
        v.exPc = pc; v.exImm = imm; v.exRs1 = rs1; v.expPc = ePc; v.expFlags = eFl;
        return v;
    endfunction

    // Drive one cycle of inputs at the falling edge, then settle just past the rising edge.
    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        rst          = v.rst;
        stall        = v.stall;
        if_ready     = v.rdy;
        ex_valid     = v.ctl[3];
        ex_is_branch = v.ctl[2];
        ex_is_jal    = v.ctl[1];
        ex_is_jalr   = v.ctl[0];
        bcomp        = v.bc;
        ex_pc        = v.exPc;
        ex_imm       = v.exImm;
        ex_rs1       = v.exRs1;
        @(posedge clk);
        #1;
    endtask

    task automatic checkBit(input string tag, input string what, input logic got, input logic exp);
        testCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s %s: got %b expected %b", tag, what, got, exp);
        end
    endtask

    task automatic checkOutput(input vec_t v, input string tag);
        testCount++;
        if (pc_o !== v.expPc) begin
            failCount++;
            $display("[TB] FAIL %s pc_o: got %h expected %h", tag, pc_o, v.expPc);
        end
        checkBit(tag, "if_valid",   if_valid,   v.expFlags[3]);
        checkBit(tag, "flush_o",    flush_o,    v.expFlags[2]);
        checkBit(tag, "redirect_o", redirect_o, v.expFlags[1]);
        checkBit(tag, "misalign_o", misalign_o, v.expFlags[0]);
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; if_ready = 1'b0; ex_valid = 1'b0;
        ex_is_branch = 1'b0; ex_is_jal = 1'b0; ex_is_jalr = 1'b0; bcomp = 1'b0;
        ex_pc = '0; ex_imm = '0; ex_rs1 = '0;

        //             rst   stall rdy   ctl     bc    ex_pc         ex_imm        ex_rs1        exp pc        flags
        vecs[0]  = mk(1'b1, 1'b0, 1'b1, C_NONE, 1'b0, 32'h0,        32'h0,        32'h0,        32'h0,        F_IDLE);
        vecs[1]  = mk(1'b0, 1'b0, 1'b1, C_NONE, 1'b0, 32'h0,        32'h0,        32'h0,        32'h0,        F_RUN);
        vecs[2]  = mk(1'b0, 1'b0, 1'b1, C_NONE, 1'b0, 32'h0,        32'h0,        32'h0,        32'h4,        F_RUN);
        vecs[3]  = mk(1'b0, 1'b0, 1'b1, C_NONE, 1'b0, 32'h0,        32'h0,        32'h0,        32'h8,        F_RUN);
        vecs[4]  = mk(1'b0, 1'b0, 1'b1, C_BR,   1'b0, 32'h100,      32'hFFFF_FFF0, 32'h0,       32'hC,        F_RUN);
        vecs[5]  = mk(1'b0, 1'b0, 1'b1, C_BR,   1'b1, 32'h100,      32'hFFFF_FFF0, 32'h0,       32'hF0,       F_REDIR);
        vecs[6]  = mk(1'b0, 1'b0, 1'b1, C_NONE, 1'b0, 32'h0,        32'h0,        32'h0,        32'hF0,       F_FLUSH);
        vecs[7]  = mk(1'b0, 1'b0, 1'b1, C_NONE, 1'b0, 32'h0,        32'h0,        32'h0,        32'hF0,       F_RUN);
        vecs[8]  = mk(1'b0, 1'b0, 1'b1, C_NONE, 1'b0, 32'h0,        32'h0,        32'h0,        32'hF4,       F_RUN);
        vecs[9]  = mk(1'b0, 1'b0, 1'b1, C_JALR, 1'b0, 32'h0,        32'h3,        32'h2001,     32'h2004,     F_REDIR);
        vecs[10] = mk(1'b0, 1'b0, 1'b1, C_BR,   1'b1, 32'h500,      32'h8,        32'h0,        32'h2004,     F_FLUSH);
        vecs[11] = mk(1'b0, 1'b1, 1'b1, C_BR,   1'b1, 32'h500,      32'h8,        32'h0,        32'h2004,     F_RUN);
        vecs[12] = mk(1'b0, 1'b1, 1'b1, C_JAL,  1'b0, 32'h40,       32'h20,       32'h0,        32'h60,       F_REDIR);
        vecs[13] = mk(1'b0, 1'b0, 1'b1, C_NONE, 1'b0, 32'h0,        32'h0,        32'h0,        32'h60,       F_FLUSH);
        vecs[14] = mk(1'b0, 1'b0, 1'b1, C_NONE, 1'b0, 32'h0,        32'h0,        32'h0,        32'h60,       F_RUN);
        vecs[15] = mk(1'b0, 1'b0, 1'b0, C_JAL,  1'b0, 32'h0,        32'hFFFF_FFFC, 32'h0,       32'hFFFF_FFFC, F_REDIR);
        vecs[16] = mk(1'b0, 1'b0, 1'b0, C_NONE, 1'b0, 32'h0,        32'h0,        32'h0,        32'hFFFF_FFFC, F_FLUSH);
        vecs[17] = mk(1'b0, 1'b0, 1'b0, C_NONE, 1'b0, 32'h0,        32'h0,        32'h0,        32'hFFFF_FFFC, F_RUN);
        vecs[18] = mk(1'b0, 1'b0, 1'b0, C_NONE, 1'b0, 32'h0,        32'h0,        32'h0,        32'hFFFF_FFFC, F_RUN);
        vecs[19] = mk(1'b0, 1'b0, 1'b1, C_NONE, 1'b0, 32'h0,        32'h0,        32'h0,        32'h0,        F_RUN);
        vecs[20] = mk(1'b0, 1'b0, 1'b1, C_JALR, 1'b0, 32'h0,        32'h1,        32'h2001,     32'h2002,     F_TRAP);
        vecs[21] = mk(1'b0, 1'b0, 1'b1, C_JAL,  1'b0, 32'h0,        32'h8,        32'h0,        32'h2002,     F_TRAP);
        vecs[22] = mk(1'b0, 1'b0, 1'b1, C_BR,   1'b1, 32'h100,      32'h40,       32'h0,        32'h2002,     F_TRAP);
        vecs[23] = mk(1'b1, 1'b0, 1'b1, C_NONE, 1'b0, 32'h0,        32'h0,        32'h0,        32'h0,        F_IDLE);
        vecs[24] = mk(1'b0, 1'b0, 1'b1, C_NONE, 1'b0, 32'h0,        32'h0,        32'h0,        32'h0,        F_RUN);
        vecs[25] = mk(1'b0, 1'b0, 1'b1, C_BR,   1'b1, 32'h10,       32'h2,        32'h0,        32'h12,       F_TRAP);
        vecs[26] = mk(1'b1, 1'b0, 1'b1, C_NONE, 1'b0, 32'h0,        32'h0,        32'h0,        32'h0,        F_IDLE);
        vecs[27] = mk(1'b0, 1'b0, 1'b1, C_NONE, 1'b0, 32'h0,        32'h0,        32'h0,        32'h0,        F_RUN);
        vecs[28] = mk(1'b0, 1'b0, 1'b1, C_XJAL, 1'b0, 32'h100,      32'h40,       32'h0,        32'h4,        F_RUN);
        vecs[29] = mk(1'b0, 1'b0, 1'b1, C_BOTH, 1'b0, 32'h100,      32'h10,       32'h3000,     32'h3010,     F_REDIR);
        vecs[30] = mk(1'b0, 1'b0, 1'b1, C_NONE, 1'b0, 32'h0,        32'h0,        32'h0,        32'h3010,     F_FLUSH);
        vecs[31] = mk(1'b0, 1'b0, 1'b1, C_NONE, 1'b0, 32'h0,        32'h0,        32'h0,        32'h3010,     F_RUN);

        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i]);
            checkOutput(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset arriving in the second flush cycle must beat the pending flush exit.
        begin
            vec_t v;
            v = mk(1'b0, 1'b0, 1'b1, C_BR, 1'b1, 32'h100, 32'h40, 32'h0, 32'h140, F_REDIR);
            applyStimulus(v); checkOutput(v, "rstFlushTaken");
            v = mk(1'b0, 1'b0, 1'b1, C_NONE, 1'b0, 32'h0, 32'h0, 32'h0, 32'h140, F_FLUSH);
            applyStimulus(v); checkOutput(v, "rstFlushSecond");
            v = mk(1'b1, 1'b0, 1'b1, C_NONE, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, F_IDLE);
            applyStimulus(v); checkOutput(v, "rstFlushReset");
            v = mk(1'b0, 1'b0, 1'b1, C_NONE, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, F_RUN);
            applyStimulus(v); checkOutput(v, "rstFlushIdle");
            v = mk(1'b0, 1'b0, 1'b1, C_NONE, 1'b0, 32'h0, 32'h0, 32'h0, 32'h4, F_RUN);
            applyStimulus(v); checkOutput(v, "stallPre");
            for (int k = 0; k < 5; k++) begin
                v = mk(1'b0, 1'b1, 1'b1, C_NONE, 1'b0, 32'h0, 32'h0, 32'h0, 32'h4, F_RUN);
                applyStimulus(v); checkOutput(v, $sformatf("stallHold%0d", k));
            end
            v = mk(1'b0, 1'b0, 1'b1, C_NONE, 1'b0, 32'h0, 32'h0, 32'h0, 32'h8, F_RUN);
            applyStimulus(v); checkOutput(v, "stallRelease");
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
